circular_dma_reader: RTL and testbench
======================================

// Module: circular_dma_reader
// PURPOSE
//  MM2S counterpart of the circular S2MM DMA: drains a circular buffer in memory through AXI4 read
//  bursts and emits its contents on an AXI-Stream master. The producer publishes a write offset;
//  this block publishes its read offset. Sits between the memory interconnect and a stream consumer.
// PARAMETERS
//  C_ADDR_WIDTH   32       M_AXI address width; also width of config/offset ports
//  C_AXIS_WIDTH   64       data width of M_AXI R channel and M_AXIS; B = C_AXIS_WIDTH/8 bytes/beat
//  C_MAX_BURST    16       max beats per AR burst (1..256)
//  C_FIFO_DEPTH   32       internal beat FIFO depth, power of 2, >= C_MAX_BURST
//  C_VALUE_ARPROT 3'd0     constant driven on m_axi_arprot
//  C_VALUE_ARCACHE 4'b1111 constant driven on m_axi_arcache
// PORTS
//  clk              in   1       clock
//  rst              in   1       reset, asynchronous, active-high
//  cfg_enable       in   1       run enable
//  cfg_base_addr    in   C_ADDR_WIDTH  buffer base, B-aligned
//  cfg_mem_size     in   C_ADDR_WIDTH  buffer size in bytes, multiple of B, nonzero
//  wr_offset        in   C_ADDR_WIDTH  producer write offset (bytes from base)
//  rd_offset        out  C_ADDR_WIDTH  bytes consumed from memory (offset of next read)
//  busy             out  1       burst in flight or FIFO non-empty
//  rresp_error      out  1       sticky: a non-OKAY RRESP was received
//  m_axi_araddr/arlen/arsize/arburst/arprot/arcache/arvalid  out; m_axi_arready in   AR channel
//  m_axi_rdata in C_AXIS_WIDTH; m_axi_rresp in 2; m_axi_rlast/rvalid in; m_axi_rready out   R channel
//  m_axis_tdata     out  C_AXIS_WIDTH  stream data
//  m_axis_tvalid    out  1 ; m_axis_tready in 1   stream handshake
// BEHAVIOUR
//  Reset: arvalid=0, rready=0, tvalid=0, rd_offset=0, busy=0, rresp_error=0, FSM=IDLE, FIFO empty.
//  Constants: arsize=log2(B), arburst=INCR, arprot/arcache from parameters.
//  Offset low log2(B) bits ignored. avail = wr_offset>=rd_offset ? wr_offset-rd_offset
//   : cfg_mem_size-rd_offset+wr_offset; equal offsets = empty (producer never fills completely).
//  FSM IDLE: if cfg_enable && avail!=0 -> CALC. If !cfg_enable: rd_offset<=0, rresp_error<=0.
//  CALC: len = min(avail/B, C_MAX_BURST, (cfg_mem_size-rd_offset)/B, (4096-addr[11:0])/B),
//   addr = cfg_base_addr+rd_offset. Stay in CALC (recomputing) until FIFO free >= len, then ADDR.
//   Free = C_FIFO_DEPTH - occupancy; only one burst outstanding, so R beats never overflow.
//  ADDR: arvalid=1, araddr/arlen=len-1 held stable until arready; then DATA. 2 cycles IDLE->arvalid.
//  DATA: rready=1; each R beat pushed into FIFO (rresp!=OKAY -> still pushed, rresp_error<=1).
//   On rlast beat: rd_offset += len*B, set to 0 when result == cfg_mem_size; -> IDLE.
//   rlast ignored for counting: beat count == len ends burst (rlast mismatch tolerated).
//  cfg_enable falling mid-burst: burst completes normally, then IDLE; FIFO keeps draining.
//  cfg changes allowed only while !cfg_enable && !busy.
//  FIFO: first-word tvalid 1 cycle after R beat accepted; simultaneous push/pop on full or empty
//   is legal and preserves order; tdata stable while tvalid && !tready.
//  busy = (FSM != IDLE) || FIFO non-empty.
//  rst asserted at any time (mid-burst included): outputs to reset values at once; in-flight
//   AXI transaction is abandoned (system resets interconnect together).
// TESTING
//  1 base=0x1000_0000 size=0x1000 wr=0x100 tready=1 -> AR 0x1000_0000 len15, AR 0x1000_0080 len15; 32 beats in order; rd_offset=0x100; busy->0
//  2 wrap: size=0x400, rd at 0x3C0, wr=0x40 -> AR base+0x3C0 len7, AR base len7; rd_offset=0x40
//  3 4KB: base=0x1000_0FC0 size=0x2000 wr=0x100 -> ARs len7 @0x0FC0, len15 @0x1000, len7 @0x1080
//  4 tready=0, wr=0x200 -> exactly two AR bursts (32 beats), no third AR until tready=1; no loss/dup
//  5 RRESP=SLVERR on one beat -> beat still streamed, rresp_error=1 until cfg_enable low in IDLE
//  6 rst pulse during DATA -> arvalid/rready/tvalid=0 immediately, rd_offset=0; restart reads from base

Source files
------------

// File: rtl/circular_dma_reader.sv
// Circular-buffer MM2S reader: drains memory through AXI4 INCR read bursts into a beat FIFO
// and streams the beats out on AXI-Stream, publishing how far the buffer has been consumed.
//
//   state | meaning
//   IDLE  | waiting for unread data; clears offset and error when disabled
//   CALC  | sizing the next burst, waiting for FIFO room
//   ADDR  | AR request presented, held until accepted
//   DATA  | accepting R beats into the FIFO until the burst's beat count is reached
module circular_dma_reader #(
   parameter int         C_ADDR_WIDTH    = 32,
   parameter int         C_AXIS_WIDTH    = 64,
   parameter int         C_MAX_BURST     = 16,
   parameter int         C_FIFO_DEPTH    = 32,
   parameter logic [2:0] C_VALUE_ARPROT  = 3'd0,
   parameter logic [3:0] C_VALUE_ARCACHE = 4'b1111
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_enable,
   input  logic [C_ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [C_ADDR_WIDTH-1:0] cfg_mem_size,
   input  logic [C_ADDR_WIDTH-1:0] wr_offset,
   output logic [C_ADDR_WIDTH-1:0] rd_offset,
   output logic                    busy,
   output logic                    rresp_error,
   output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic [2:0]              m_axi_arprot,
   output logic [3:0]              m_axi_arcache,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [C_AXIS_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready
);

   localparam int AW = C_ADDR_WIDTH;
   localparam int B  = C_AXIS_WIDTH / 8;
   localparam int LB = $clog2(B);
   localparam int FA = $clog2(C_FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_ADDR = 2'd2;
   localparam logic [1:0] ST_DATA = 2'd3;

   logic [1:0]    r_state;
   logic [AW-1:0] r_rd_offset;
   logic          r_err;
   logic [AW-1:0] r_len;
   logic [AW-1:0] r_araddr;
   logic [AW-1:0] r_beats_left;

   logic [C_AXIS_WIDTH-1:0] r_mem [C_FIFO_DEPTH];
   logic [FA-1:0]           r_wptr;
   logic [FA-1:0]           r_rptr;
   logic [FA:0]             r_count;

   logic [AW-1:0] w_wr_al;
   logic [AW-1:0] w_avail;
   logic [AW-1:0] w_to_end;
   logic [AW-1:0] w_addr;
   logic [AW-1:0] w_to_4k;
   logic [AW-1:0] w_beats;
   logic [AW-1:0] w_free;
   logic [AW-1:0] w_next;
   logic          w_push;
   logic          w_pop;
   logic          w_unused;

   // rlast is deliberately not trusted; the beat count alone closes a burst
   assign w_unused = &{1'b0, m_axi_rlast, wr_offset[LB-1:0]};

   assign w_wr_al  = {wr_offset[AW-1:LB], {LB{1'b0}}};
   assign w_avail  = (w_wr_al >= r_rd_offset) ? (w_wr_al - r_rd_offset)
                                              : (cfg_mem_size - r_rd_offset + w_wr_al);
   assign w_to_end = cfg_mem_size - r_rd_offset;
   assign w_addr   = cfg_base_addr + r_rd_offset;
   assign w_to_4k  = AW'(13'h1000) - AW'(w_addr[11:0]);
   assign w_free   = AW'(C_FIFO_DEPTH) - AW'(r_count);
   assign w_next   = r_rd_offset + (r_len << LB);

   always_comb begin
      w_beats = AW'(C_MAX_BURST);
      if ((w_avail >> LB) < w_beats)
         w_beats = w_avail >> LB;
      if ((w_to_end >> LB) < w_beats)
         w_beats = w_to_end >> LB;
      if ((w_to_4k >> LB) < w_beats)
         w_beats = w_to_4k >> LB;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rd_offset  <= '0;
         r_err        <= 1'b0;
         r_len        <= '0;
         r_araddr     <= '0;
         r_beats_left <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!cfg_enable) begin
                  r_rd_offset <= '0;
                  r_err       <= 1'b0;
               end else if (w_avail != '0) begin
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_len    <= w_beats;
               r_araddr <= w_addr;
               if (w_beats == '0)
                  r_state <= ST_IDLE;
               else if (w_free >= w_beats)
                  r_state <= ST_ADDR;
            end
            ST_ADDR: begin
               if (m_axi_arready) begin
                  r_beats_left <= r_len;
                  r_state      <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (m_axi_rvalid) begin
                  if (m_axi_rresp != 2'b00)
                     r_err <= 1'b1;
                  if (r_beats_left == AW'(1)) begin
                     r_rd_offset <= (w_next == cfg_mem_size) ? '0 : w_next;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_beats_left <= r_beats_left - AW'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Room for the whole burst is reserved in CALC, so every R beat can be pushed unconditionally
   assign w_push = (r_state == ST_DATA) && m_axi_rvalid;
   assign w_pop  = m_axis_tvalid && m_axis_tready;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= m_axi_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + FA'(1);
         if (w_pop)
            r_rptr <= r_rptr + FA'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (FA+1)'(1);
            2'b01:   r_count <= r_count - (FA+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign m_axis_tvalid = (r_count != '0);
   assign m_axis_tdata  = r_mem[r_rptr];

   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = 8'(r_len - AW'(1));
   assign m_axi_arsize  = 3'(LB);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arprot  = C_VALUE_ARPROT;
   assign m_axi_arcache = C_VALUE_ARCACHE;
   assign m_axi_arvalid = (r_state == ST_ADDR);
   assign m_axi_rready  = (r_state == ST_DATA);

   assign rd_offset   = r_rd_offset;
   assign rresp_error = r_err;
   assign busy        = (r_state != ST_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_circular_dma_reader.sv
// Scoreboard bench for circular_dma_reader: an AXI read slave serves address-derived data,
// expected AR requests and stream beats are queued by the directed tests and popped by monitors.
module tb_circular_dma_reader;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } ar_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_enable;
   logic [31:0] cfg_base_addr;
   logic [31:0] cfg_mem_size;
   logic [31:0] wr_offset;
   logic [31:0] rd_offset;
   logic        busy;
   logic        rresp_error;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic [2:0]  m_axi_arprot;
   logic [3:0]  m_axi_arcache;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;

   int          tests_run = 0;
   int          fails = 0;
   int          beats_seen = 0;
   ar_t         exp_ar_q[$];
   logic [63:0] exp_beat_q[$];
   ar_t         slv_q[$];
   bit          r_gaps = 1'b0;
   bit          tr_rand = 1'b0;
   bit          tr_val = 1'b1;
   logic [31:0] err_addr = 32'hFFFF_FFFF;

   circular_dma_reader dut (
      .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_base_addr(cfg_base_addr),
      .cfg_mem_size(cfg_mem_size), .wr_offset(wr_offset), .rd_offset(rd_offset),
      .busy(busy), .rresp_error(rresp_error),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot), .m_axi_arcache(m_axi_arcache),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a, a ^ 32'hDEAD_BEEF};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests_run++;
      fails++;
      $display("FAIL %s: event occurred or bound expired, expected otherwise", name);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_burst(input logic [31:0] a, input int n);
      ar_t t;
      t.addr = a;
      t.len  = 8'(n - 1);
      exp_ar_q.push_back(t);
      for (int i = 0; i < n; i++)
         exp_beat_q.push_back(mem_word(a + 32'(i * 8)));
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      step(3);
      while (k < budget && (busy || exp_beat_q.size() != 0 || exp_ar_q.size() != 0)) begin
         step(1);
         k++;
      end
      if (k >= budget)
         fail_now({name, "_timeout"});
      step(2);
   endtask

   task automatic setup(input logic [31:0] base, input logic [31:0] size);
      cfg_enable = 1'b0;
      wr_offset  = '0;
      step(2);
      cfg_base_addr = base;
      cfg_mem_size  = size;
      cfg_enable    = 1'b1;
      step(1);
   endtask

   always @(posedge clk) begin
      #1;
      m_axis_tready = tr_rand ? 1'($urandom_range(0, 1)) : tr_val;
   end

   // AXI read slave; AR requests are checked against the scoreboard as they are accepted
   initial begin : slave
      bit          ar_take, r_take, active;
      ar_t         cur, t, e;
      int          beat;
      logic [31:0] a;
      active = 1'b0;
      beat = 0;
      cur = '0;
      m_axi_arready = 1'b1;
      m_axi_rvalid  = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      m_axi_rlast   = 1'b0;
      forever begin
         @(negedge clk);
         ar_take = m_axi_arvalid && m_axi_arready && !rst;
         r_take  = m_axi_rvalid && m_axi_rready && !rst;
         if (ar_take) begin
            t.addr = m_axi_araddr;
            t.len  = m_axi_arlen;
            slv_q.push_back(t);
            if (exp_ar_q.size() == 0) begin
               fail_now("ar_unexpected");
            end else begin
               e = exp_ar_q.pop_front();
               check("ar_addr", 64'(m_axi_araddr), 64'(e.addr));
               check("ar_len", 64'(m_axi_arlen), 64'(e.len));
            end
         end
         @(posedge clk);
         #1;
         if (rst) begin
            slv_q.delete();
            active = 1'b0;
            beat = 0;
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
         end else begin
            if (r_take) begin
               beat++;
               if (beat == int'(cur.len) + 1)
                  active = 1'b0;
            end
            if (!active && slv_q.size() > 0) begin
               cur = slv_q.pop_front();
               active = 1'b1;
               beat = 0;
            end
            if (active) begin
               a = cur.addr + 32'(beat * 8);
               if (!(m_axi_rvalid && !r_take))
                  m_axi_rvalid = r_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
               m_axi_rdata = mem_word(a);
               m_axi_rresp = (a == err_addr) ? 2'b10 : 2'b00;
               m_axi_rlast = (beat == int'(cur.len));
            end else begin
               m_axi_rvalid = 1'b0;
               m_axi_rlast  = 1'b0;
            end
         end
      end
   end

   logic [63:0] held;
   bit          hold_pend = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend && m_axis_tvalid)
            check("tdata_stable", m_axis_tdata, held);
         hold_pend = 1'b0;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_beat_q.size() == 0) begin
               fail_now("beat_unexpected");
            end else begin
               check("beat", m_axis_tdata, exp_beat_q.pop_front());
               beats_seen++;
            end
         end else if (m_axis_tvalid) begin
            held = m_axis_tdata;
            hold_pend = 1'b1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int b0, k;
      rst = 1'b1;
      cfg_enable = 1'b0;
      cfg_base_addr = '0;
      cfg_mem_size = 32'h1000;
      wr_offset = '0;
      step(3);
      check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("rst_rready", 64'(m_axi_rready), 64'd0);
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_rd_offset", 64'(rd_offset), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rresp_error", 64'(rresp_error), 64'd0);
      check("arsize", 64'(m_axi_arsize), 64'd3);
      check("arburst", 64'(m_axi_arburst), 64'd1);
      check("arprot", 64'(m_axi_arprot), 64'd0);
      check("arcache", 64'(m_axi_arcache), 64'hF);
      rst = 1'b0;
      step(2);

      // 1: two full bursts
      setup(32'h1000_0000, 32'h1000);
      check("t1_idle_empty", 64'(busy), 64'd0);
      exp_burst(32'h1000_0000, 16);
      exp_burst(32'h1000_0080, 16);
      wr_offset = 32'h100;
      wait_idle("t1", 2000);
      check("t1_rd_offset", 64'(rd_offset), 64'h100);
      check("t1_busy", 64'(busy), 64'd0);

      // 2: advance to 0x3C0, then wrap around the end of the buffer
      setup(32'h2000_0000, 32'h400);
      r_gaps = 1'b1;
      for (int i = 0; i < 7; i++)
         exp_burst(32'h2000_0000 + 32'(i * 32'h80), 16);
      exp_burst(32'h2000_0380, 8);
      wr_offset = 32'h3C0;
      wait_idle("t2a", 4000);
      check("t2_rd_pre", 64'(rd_offset), 64'h3C0);
      exp_burst(32'h2000_03C0, 8);
      exp_burst(32'h2000_0000, 8);
      wr_offset = 32'h40;
      wait_idle("t2b", 2000);
      check("t2_rd_offset", 64'(rd_offset), 64'h40);
      r_gaps = 1'b0;

      // 3: 4KB boundary split, random consumer backpressure
      setup(32'h1000_0FC0, 32'h2000);
      tr_rand = 1'b1;
      exp_burst(32'h1000_0FC0, 8);
      exp_burst(32'h1000_1000, 16);
      exp_burst(32'h1000_1080, 8);
      wr_offset = 32'h100;
      wait_idle("t3", 3000);
      check("t3_rd_offset", 64'(rd_offset), 64'h100);
      tr_rand = 1'b0;

      // 4: stalled consumer fills the FIFO after two bursts
      setup(32'h5000_0000, 32'h1000);
      tr_val = 1'b0;
      step(2);
      for (int i = 0; i < 4; i++)
         exp_burst(32'h5000_0000 + 32'(i * 32'h80), 16);
      wr_offset = 32'h200;
      step(300);
      check("t4_ars_pending", 64'(exp_ar_q.size()), 64'd2);
      check("t4_beats_pending", 64'(exp_beat_q.size()), 64'd64);
      check("t4_busy", 64'(busy), 64'd1);
      check("t4_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("t4_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("t4_rd_mid", 64'(rd_offset), 64'h100);
      tr_val = 1'b1;
      wait_idle("t4", 3000);
      check("t4_rd_offset", 64'(rd_offset), 64'h200);

      // 5: SLVERR on one beat
      setup(32'h3000_0000, 32'h1000);
      err_addr = 32'h3000_0018;
      exp_burst(32'h3000_0000, 8);
      wr_offset = 32'h40;
      wait_idle("t5", 1000);
      check("t5_rresp_error", 64'(rresp_error), 64'd1);
      check("t5_rd_offset", 64'(rd_offset), 64'h40);
      step(5);
      check("t5_error_sticky", 64'(rresp_error), 64'd1);
      cfg_enable = 1'b0;
      step(2);
      check("t5_error_clear", 64'(rresp_error), 64'd0);
      check("t5_rd_clear", 64'(rd_offset), 64'd0);
      err_addr = 32'hFFFF_FFFF;

      // 6: reset in the middle of a burst, then restart from base
      setup(32'h4000_0000, 32'h1000);
      exp_burst(32'h4000_0000, 16);
      exp_burst(32'h4000_0080, 16);
      b0 = beats_seen;
      wr_offset = 32'h100;
      k = 0;
      while (k < 500 && !(beats_seen >= b0 + 4 && m_axi_rready)) begin
         step(1);
         k++;
      end
      if (k >= 500)
         fail_now("t6_reach_data_timeout");
      rst = 1'b1;
      #1;
      check("t6_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("t6_rready", 64'(m_axi_rready), 64'd0);
      check("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("t6_rd_offset", 64'(rd_offset), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      exp_ar_q.delete();
      exp_beat_q.delete();
      step(3);
      exp_burst(32'h4000_0000, 16);
      exp_burst(32'h4000_0080, 16);
      rst = 1'b0;
      wait_idle("t6", 2000);
      check("t6_rd_final", 64'(rd_offset), 64'h100);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
